// File: rtl/piso_tx_scheduler.sv
// Round-robin grant and 128-cycle framing for the AES output serializer.
// Define PISO_SCHED_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module piso_tx_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 128,
  parameter int SRC_W   = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      piso_wr_en,
  output logic [DATA_W-1:0]         piso_data,
  output logic                      ser_valid,
  output logic                      ser_first,
  output logic                      ser_last,
  output logic [SRC_W-1:0]          ser_src,
  output logic                      busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int NPAD  = 2**SRC_W;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W-1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] bit_cnt, cnt_nx;
  logic [SRC_W-1:0] rr_ptr, ptr_nx;
  logic [SRC_W-1:0] src_nx;
  logic [SRC_W-1:0] gnt_idx, idx;
  logic [NPAD-1:0]  vld_pad;
  logic             found;
  logic             load_slot;
  logic             grant;

  assign vld_pad = NPAD'(req_valid);

  assign load_slot = (state == IDLE) ||
                     (state == SHIFT && bit_cnt == CNT_MAX);

  // No grant while reset is held so every output reads zero.
  assign grant = reset_n & load_slot & found;

  // Pick the winning requester among the valid ones.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = '0;
`ifdef PISO_SCHED_FIXED_PRIO_EN
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = SRC_W'(k);
      if (!found && vld_pad[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
`else
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = SRC_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && vld_pad[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
`endif
  end

  // Drive the accept strobe and serializer load from the grant.
  always_comb begin
    req_ready  = '0;
    piso_wr_en = grant;
    piso_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant && gnt_idx == SRC_W'(i)) begin
        req_ready[i] = 1'b1;
        piso_data    = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state: load on grant, otherwise count the shift cycles.
  always_comb begin
    state_nx = state;
    cnt_nx   = bit_cnt;
    ptr_nx   = rr_ptr;
    src_nx   = ser_src;
    if (grant) begin
      state_nx = SHIFT;
      cnt_nx   = '0;
      src_nx   = gnt_idx;
`ifndef PISO_SCHED_FIXED_PRIO_EN
      ptr_nx   = gnt_idx;
`endif
    end else begin
      unique case (state)
        SHIFT: begin
          if (bit_cnt == CNT_MAX) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = bit_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State, counter, pointer and source registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      rr_ptr  <= SRC_W'(NUM_REQ-1);
      ser_src <= '0;
    end else begin
      state   <= state_nx;
      bit_cnt <= cnt_nx;
      rr_ptr  <= ptr_nx;
      ser_src <= src_nx;
    end
  end

  assign ser_valid = (state == SHIFT);
  assign busy      = (state == SHIFT);
  assign ser_first = (state == SHIFT) && (bit_cnt == '0);
  assign ser_last  = (state == SHIFT) && (bit_cnt == CNT_MAX);

endmodule

// File: doc/piso_tx_scheduler.md
Name: piso_tx_scheduler

Overview:
Arbitration and sequencing controller for the 128-bit parallel-in/serial-out serializer at the AES-128 output.
- Accepts 128-bit blocks from NUM_REQ requesters (e.g. ciphertext path, key/debug readback) over valid/ready handshakes.
- Grants the serializer round-robin and drives its load strobe and parallel data.
- Counts the 128 shift cycles and emits framing qualifiers (valid/first/last/source) aligned to the serializer's serial output bit.

Parameters:
NUM_REQ, 2, number of requesters; legal range 2..4.
DATA_W, 128, block width; must equal the serializer width.
SRC_W, 2, width of the source-id output; must satisfy 2**SRC_W >= NUM_REQ.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset_n  input  1  reset, asynchronous, active-low. The serializer is driven by the same reset_n.
req_valid  input  NUM_REQ  per-requester block-available flag.
req_data  input  NUM_REQ*DATA_W  flattened blocks; requester i occupies bits [i*DATA_W +: DATA_W].
req_ready  output  NUM_REQ  one-hot accept strobe; a transfer occurs when valid&ready.
piso_wr_en  output  1  serializer load strobe.
piso_data  output  DATA_W  data for the serializer's parallel input.
ser_valid  output  1  serializer output bit is a live data bit this cycle.
ser_first  output  1  current serial bit is bit 0 of the frame.
ser_last  output  1  current serial bit is bit DATA_W-1 of the frame.
ser_src  output  SRC_W  index of the requester owning the current frame.
busy  output  1  high whenever state is SHIFT.

Behaviour:
- Reset values: state IDLE, bit_cnt 0, ser_src 0, rr_ptr NUM_REQ-1 (so requester 0 wins first), ser_valid/ser_first/ser_last/busy 0. Reset asserted mid-frame aborts the frame immediately; no resume.
- Combinational outputs: req_ready, piso_wr_en and piso_data are combinational. All other outputs are registered or decoded from registered state.
- States: IDLE and SHIFT.
- load_slot = (state==IDLE) | (state==SHIFT & bit_cnt==DATA_W-1).
- Grant: in a load_slot with any req_valid set, grant goes to the first valid requester found searching upward from rr_ptr+1 (mod NUM_REQ).
  - piso_wr_en=1, piso_data=req_data of the grantee, req_ready[grantee]=1.
  - On the clock edge: rr_ptr<=grantee, ser_src<=grantee, bit_cnt<=0, state<=SHIFT.
- Idle outputs: outside a load_slot, or when no valid is set, piso_wr_en=0, req_ready=0 and piso_data=0.
- Latency: frame bit 0 appears on the serializer output in the cycle after acceptance. Bits are LSB-first, one per cycle, for DATA_W cycles.
- SHIFT:
  - ser_valid=1; ser_first=(bit_cnt==0); ser_last=(bit_cnt==DATA_W-1); bit_cnt increments each cycle.
  - On the last bit, a new grant reloads back-to-back with zero idle cycles. If no request is pending, state<=IDLE and ser_valid falls the following cycle.
- Requesters hold valid and data stable until accepted. Deasserting valid before acceptance withdraws the request (no error).
- bit_cnt is $clog2(DATA_W) bits wide. It is reset to 0 on every load, so wrap-around never occurs.
- Simultaneous requests: exactly one grant per load_slot. Losers remain pending and are served in rotation order; no requester waits more than NUM_REQ-1 frames.

Optional Feature:
PISO_SCHED_FIXED_PRIO_EN
- Defined: fixed priority; the lowest valid index always wins, and rr_ptr is neither updated nor used. Starvation of high indices is accepted.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
1. Single frame: reset, then req_valid[0]=1, data=128'h0123456789ABCDEF_FEDCBA9876543210 -> req_ready[0] and piso_wr_en high for 1 cycle. Next 128 cycles: serial bits equal data LSB-first, ser_first on cycle 1, ser_last on cycle 128, ser_src=0. Cycle 129: ser_valid=0, busy=0.
2. Back-to-back: req 1 holds valid with two blocks A then B -> the second piso_wr_en coincides with ser_last of A. B bit 0 follows with no gap; 256 consecutive ser_valid cycles.
3. Contention: both requesters valid continuously -> grants alternate 0,1,0,1 over 4 frames; ser_src matches each frame.
4. Fixed priority with PISO_SCHED_FIXED_PRIO_EN defined: same stimulus as test 3 -> requester 0 granted all 4 frames; req_ready[1] never asserts.
5. Reset mid-frame: reset_n low at bit_cnt=60 -> all outputs 0 asynchronously. After release, pending req_valid[1] is granted on the first cycle; frame restarts at bit 0.
6. Withdrawn request: req_valid[1] pulses during SHIFT and drops before the load_slot -> no grant, state returns to IDLE, req_ready stays 0.
